cam_vsync_conditioner: RTL and testbench
========================================

# cam_vsync_conditioner

Conditions the raw camera VSYNC into a clean, glitch-free frame strobe in the `clk50` domain, feeding the frame-rate monitor and any frame-synchronous logic downstream. It synchronises and filters the asynchronous camera signal and produces a one-cycle frame-start pulse. It also measures the frame period in clock cycles, counts frames, and flags a camera stall when no frame start arrives within a timeout.

## Interface
- `FILTER_LEN`, 4: consecutive cycles the synchronised input must disagree with `vs` before `vs` toggles (range 1..255).
- `TIMEOUT`, 32'd50_000_000: cycles without a frame start before `stall` asserts (1 s at 50 MHz).
- `CNT_W`, 32: width of the period counter and `frame_period`.

- `clk50` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `vs_raw` in 1: camera VSYNC, asynchronous to `clk50`.
- `vs` out 1: filtered VSYNC level.
- `vs_rise` out 1: one-cycle pulse on each filtered rising edge (frame start).
- `frame_period` out CNT_W: cycles between the last two `vs_rise` pulses.
- `period_valid` out 1: `frame_period` holds a valid measurement.
- `frame_cnt` out 16: count of `vs_rise` pulses since reset, wrapping.
- `stall` out 1: no frame start seen within `TIMEOUT` cycles.

## Operation
- **Reset values**
  - All outputs 0.
  - Synchroniser flops, filter counter and period counter 0.
  - State is IDLE.
- **Synchroniser:** two flops, `vs_raw` to `s2`.
- **Filter**
  - While `s2 == vs`, the filter counter clears.
  - While `s2 != vs`, the counter increments.
  - When the counter reaches `FILTER_LEN-1` and `s2 != vs` still holds, `vs <= s2` and the counter clears.
  - A glitch shorter than `FILTER_LEN` cycles never reaches `vs`.
- **Edge detect:** `vs_rise` is 1 in the first cycle `vs` reads 1 after reading 0. It is registered alongside `vs`.
- **Period counter (`pcnt`)**
  - Clears to 0 in every `vs_rise` cycle.
  - Otherwise increments, saturating at all-ones.
- **State machine**
  - IDLE → ARMED on `vs_rise`. Measurement starts; `period_valid` stays 0.
  - ARMED → LOCKED on `vs_rise`: `frame_period <= pcnt + 1` (saturating) and `period_valid <= 1`.
  - LOCKED → LOCKED on `vs_rise`: `frame_period` updates the same way.
  - IDLE, ARMED or LOCKED → STALLED when `pcnt == TIMEOUT-1` with no `vs_rise` in that cycle. Effects: `stall <= 1`, `period_valid <= 0`; `frame_period` holds its last value.
  - STALLED → ARMED on `vs_rise`: `stall <= 0`.
  - In IDLE, `pcnt` counts from reset, so a camera that never starts stalls after `TIMEOUT` cycles.
- **Frame counter:** `frame_cnt` increments on each `vs_rise`; 0xFFFF wraps to 0x0000.
- **Simultaneous events:** if `vs_rise` coincides with the timeout cycle, `vs_rise` wins. No stall is raised and the normal transition applies.
- **Saturation:** a period longer than 2^CNT_W−1 reports all-ones. This is only reachable when `TIMEOUT` exceeds the counter range.
- **Mid-operation reset:** `rst` asserted at any time forces every register to its reset value immediately. No pulse is emitted on reset release.

## Timing
- Rising or falling edge of `vs_raw` to `vs` change: 2 sync cycles + `FILTER_LEN` cycles.
- `vs_rise` asserts in the same cycle `vs` becomes 1.
- Same-cycle updates with `vs_rise`:
  - `frame_period`, `period_valid` and `frame_cnt` update on the clock edge that ends the `vs_rise` cycle and are visible in the next cycle.
  - `stall` deassertion follows the same edge.
- Stall: asserts registered one cycle after the cycle with `pcnt == TIMEOUT-1`.
- `vs_rise` never asserts on two consecutive cycles.

## Structure
- Shared package `cam_pkg`:
  - state enum `vsc_state_t` {IDLE, ARMED, LOCKED, STALLED};
  - default constants `CLK50_HZ` and `VSC_FILTER_LEN_DEF`.
- Sub-module `vsync_filter` holds the 2-flop synchroniser and the glitch filter and outputs `vs`. Edge detect, period counter, FSM and frame counter stay in the top module.

## Test plan
- Pulse `vs_raw` high for 3 cycles with `FILTER_LEN=4` → `vs`, `vs_rise` and `frame_cnt` remain 0.
- Square wave on `vs_raw`, period 1000 cycles, over 3 frames (`TIMEOUT=5000`):
  - first `vs_rise` 2+4 cycles after the first rising edge;
  - `period_valid=1` after the 2nd rise, with `frame_period=1000`;
  - `frame_cnt=3`.
- With `TIMEOUT=5000`, stop `vs_raw` after lock → `stall=1` and `period_valid=0` one cycle after `pcnt` reaches 4999. The next rise clears `stall`; `period_valid` returns 1 only after the following rise.
- Hold `vs_raw=0` from reset with `TIMEOUT=5000` → `stall=1` at cycle 5000 after reset release.
- Preload 0xFFFF frames (force or 65535 short frames) then one more rise → `frame_cnt=0x0000`.
- Assert `rst` mid-frame while LOCKED → all outputs 0 immediately. The first rise after release yields ARMED with `period_valid=0`.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default constants for the camera VSYNC conditioning logic.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED,
    STALLED
  } vsc_state_t;

  localparam int unsigned CLK50_HZ           = 50_000_000;
  localparam int unsigned VSC_FILTER_LEN_DEF = 4;

endpackage

// File: rtl/vsync_filter.sv
// Two-flop synchroniser plus a run-length glitch filter for the raw camera VSYNC.
// vs_next exposes the level vs will take after the coming edge, for edge detection.
module vsync_filter
  import cam_pkg::*;
#(
  parameter int unsigned FILTER_LEN = VSC_FILTER_LEN_DEF
) (
  input  logic clk50,
  input  logic rst,
  input  logic vs_raw,
  output logic vs,
  output logic vs_next
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic       s1_q;
  logic       s2_q;
  logic       vs_q;
  logic       vs_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // NOTE: defaults are assigned first so every path drives cnt_d and vs_d; no latch.
  always_comb begin
    cnt_d = '0;
    vs_d  = vs_q;
    if (s2_q != vs_q) begin
      if (cnt_q == CNT_LAST) begin
        vs_d = s2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      vs_q  <= 1'b0;
    end else begin
      s1_q  <= vs_raw;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      vs_q  <= vs_d;
    end
  end

  assign vs      = vs_q;
  assign vs_next = vs_d;

endmodule

// File: rtl/cam_vsync_conditioner.sv
// Turns the asynchronous camera VSYNC into a clean frame-start strobe and tracks
// frame period, frame count and camera stall in the clk50 domain.
module cam_vsync_conditioner
  import cam_pkg::*;
#(
  parameter int unsigned FILTER_LEN = VSC_FILTER_LEN_DEF,
  parameter logic [31:0] TIMEOUT    = 32'(CLK50_HZ),
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             vs_raw,
  output logic             vs,
  output logic             vs_rise,
  output logic [CNT_W-1:0] frame_period,
  output logic             period_valid,
  output logic [15:0]      frame_cnt,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_filt;
  logic             vs_next;
  logic             rise_q,         rise_d;
  logic [CNT_W-1:0] pcnt_q,         pcnt_d;
  logic [CNT_W-1:0] pcnt_inc;
  vsc_state_t       state_q,        state_d;
  logic [CNT_W-1:0] frame_period_q, frame_period_d;
  logic             period_valid_q, period_valid_d;
  logic [15:0]      frame_cnt_q,    frame_cnt_d;
  logic             stall_q,        stall_d;
  logic             timeout_hit;

  vsync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk50  (clk50),
    .rst    (rst),
    .vs_raw (vs_raw),
    .vs     (vs_filt),
    .vs_next(vs_next)
  );

  // Saturating increment doubles as the "pcnt + 1" period measurement.
  assign pcnt_inc    = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_W'(1);
  // Wide compare so a TIMEOUT beyond the counter range simply never trips.
  assign timeout_hit = (64'(pcnt_q) == (64'(TIMEOUT) - 64'd1));

  always_comb begin
    rise_d         = vs_next & ~vs_filt;
    pcnt_d         = rise_q ? '0 : pcnt_inc;
    state_d        = state_q;
    frame_period_d = frame_period_q;
    period_valid_d = period_valid_q;
    frame_cnt_d    = frame_cnt_q;
    stall_d        = stall_q;

    // A frame start in the timeout cycle takes priority over raising a stall.
    if (rise_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      stall_d     = 1'b0;
      case (state_q)
        IDLE, STALLED: state_d = ARMED;
        ARMED, LOCKED: begin
          state_d        = LOCKED;
          frame_period_d = pcnt_inc;
          period_valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit && (state_q != STALLED)) begin
      state_d        = STALLED;
      stall_d        = 1'b1;
      period_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      rise_q         <= 1'b0;
      pcnt_q         <= '0;
      state_q        <= IDLE;
      frame_period_q <= '0;
      period_valid_q <= 1'b0;
      frame_cnt_q    <= '0;
      stall_q        <= 1'b0;
    end else begin
      rise_q         <= rise_d;
      pcnt_q         <= pcnt_d;
      state_q        <= state_d;
      frame_period_q <= frame_period_d;
      period_valid_q <= period_valid_d;
      frame_cnt_q    <= frame_cnt_d;
      stall_q        <= stall_d;
    end
  end

  assign vs           = vs_filt;
  assign vs_rise      = rise_q;
  assign frame_period = frame_period_q;
  assign period_valid = period_valid_q;
  assign frame_cnt    = frame_cnt_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_cam_vsync_conditioner.sv
// Self-checking bench: a timestamp-based reference model predicts every output each cycle.
module tb_cam_vsync_conditioner;

  localparam int F  = 4;
  localparam int TO = 5000;

  logic        clk50 = 1'b0;
  logic        rst   = 1'b1;
  logic        vs_raw = 1'b0;
  logic        vs;
  logic        vs_rise;
  logic [31:0] frame_period;
  logic        period_valid;
  logic [15:0] frame_cnt;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  cam_vsync_conditioner #(
    .FILTER_LEN(F),
    .TIMEOUT   (32'(TO)),
    .CNT_W     (32)
  ) dut (
    .clk50       (clk50),
    .rst         (rst),
    .vs_raw      (vs_raw),
    .vs          (vs),
    .vs_rise     (vs_rise),
    .frame_period(frame_period),
    .period_valid(period_valid),
    .frame_cnt   (frame_cnt),
    .stall       (stall)
  );

  always #5 clk50 = ~clk50;

  // Reference model: vs follows the synchronised input once the last F samples
  // agree on a new level; period = distance between rise cycles; stall = TO
  // cycles elapsed since the last rise (or reset) with nothing arriving.
  longint      m_cyc, m_anchor, m_last;
  bit          m_s1, m_s2, m_vs, m_rise, m_have_ref;
  bit          win[$];
  logic        exp_valid, exp_stall;
  logic [31:0] exp_period;
  int          m_rises;
  int          cnt_offset = 0;

  initial begin
    forever begin
      @(posedge clk50 or posedge rst);
      if (rst) begin
        m_cyc = 0; m_anchor = 0; m_last = 0;
        m_s1 = 0; m_s2 = 0; m_vs = 0; m_rise = 0; m_have_ref = 0;
        exp_valid = 0; exp_stall = 0; exp_period = '0; m_rises = 0;
        win.delete();
        for (int i = 0; i < F; i++) win.push_back(1'b0);
      end else begin
        bit same;
        if (m_rise) begin
          if (m_have_ref) begin
            exp_period = 32'(m_cyc - m_last);
            exp_valid  = 1'b1;
          end
          m_have_ref = 1;
          exp_stall  = 1'b0;
          m_last     = m_cyc;
          m_anchor   = m_cyc + 1;
          m_rises++;
        end else if (!exp_stall && (m_cyc - m_anchor == TO - 1)) begin
          exp_stall  = 1'b1;
          exp_valid  = 1'b0;
          m_have_ref = 0;
        end
        win.push_back(m_s2);
        void'(win.pop_front());
        m_s2 = m_s1;
        m_s1 = vs_raw;
        same = 1;
        for (int i = 1; i < F; i++) if (win[i] != win[0]) same = 0;
        m_rise = 0;
        if (same && (win[0] != m_vs)) begin
          m_rise = win[0];
          m_vs   = win[0];
        end
        m_cyc++;
      end
    end
  end

  logic [51:0] obs_all, exp_all;
  assign obs_all = {vs, vs_rise, period_valid, stall, frame_cnt, frame_period};
  assign exp_all = {m_vs, m_rise, exp_valid, exp_stall, 16'(m_rises + cnt_offset), exp_period};

  task automatic do_reset();
    @(negedge clk50);
    rst = 1'b1; vs_raw = 1'b0; cnt_offset = 0;
    repeat (3) @(negedge clk50);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk50);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_all !== 52'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", obs_all, 52'd0);
    end
    repeat (3) @(negedge clk50);
    vs_raw = 1'b0; rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk50);
      n_cmp++;
      if ((vs_rise !== 1'b0) || (obs_all !== exp_all)) begin
        n_bad++; $display("FAIL reset_release: got %h expected %h", obs_all, exp_all);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (5) @(negedge clk50);
    for (int k = 0; k < 25; k++) begin
      vs_raw = (k < 3);
      @(negedge clk50);
      n_cmp++;
      if ((vs !== 1'b0) || (vs_rise !== 1'b0) || (frame_cnt !== 16'd0) || (obs_all !== exp_all)) begin
        n_bad++; $display("FAIL glitch_3cyc: got %h expected %h", obs_all, exp_all);
      end
    end
  endtask

  task automatic test_square();
    int first_k;
    first_k = -1;
    do_reset();
    repeat (10) @(negedge clk50);
    for (int k = 0; k < 3000; k++) begin
      vs_raw = ((k % 1000) < 500);
      @(negedge clk50);
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_bad++; $display("FAIL square_cycle%0d: got %h expected %h", k, obs_all, exp_all);
      end
      if (vs_rise && (first_k < 0)) first_k = k + 1;
    end
    n_cmp++;
    if (first_k !== 6) begin
      n_bad++; $display("FAIL first_rise_latency: got %0d expected %0d", first_k, 6);
    end
    n_cmp++;
    if ((frame_cnt !== 16'd3) || (period_valid !== 1'b1) || (frame_period !== 32'd1000)) begin
      n_bad++;
      $display("FAIL square_final: got cnt=%0d valid=%0b period=%0d expected cnt=3 valid=1 period=1000",
               frame_cnt, period_valid, frame_period);
    end
  endtask

  task automatic test_stall();
    int last_rise, stall_k, nrise;
    bit prev_rise;
    last_rise = -1; stall_k = -1; nrise = 0; prev_rise = 0;
    do_reset();
    repeat (10) @(negedge clk50);
    for (int k = 0; k < 9000; k++) begin
      vs_raw = (k < 2000) && ((k % 1000) < 500);
      @(negedge clk50);
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_bad++; $display("FAIL stall_cycle%0d: got %h expected %h", k, obs_all, exp_all);
      end
      if (vs_rise) last_rise = k + 1;
      if (stall) begin
        stall_k = k + 1;
        break;
      end
    end
    n_cmp++;
    if ((stall_k < 0) || (stall_k - last_rise !== 5001)) begin
      n_bad++; $display("FAIL stall_latency: got %0d expected %0d", stall_k - last_rise, 5001);
    end
    n_cmp++;
    if ((period_valid !== 1'b0) || (frame_period !== 32'd1000)) begin
      n_bad++; $display("FAIL stall_outputs: got valid=%0b period=%0d expected valid=0 period=1000",
                        period_valid, frame_period);
    end
    for (int k = 0; k < 2100; k++) begin
      vs_raw = ((k % 1000) < 500);
      @(negedge clk50);
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_bad++; $display("FAIL recover_cycle%0d: got %h expected %h", k, obs_all, exp_all);
      end
      if (prev_rise && (nrise == 1)) begin
        n_cmp++;
        if ((stall !== 1'b0) || (period_valid !== 1'b0)) begin
          n_bad++; $display("FAIL recover_first_rise: got stall=%0b valid=%0b expected stall=0 valid=0",
                            stall, period_valid);
        end
      end
      if (prev_rise && (nrise == 2)) begin
        n_cmp++;
        if (period_valid !== 1'b1) begin
          n_bad++; $display("FAIL recover_second_rise: got valid=%0b expected valid=1", period_valid);
        end
      end
      prev_rise = vs_rise;
      if (vs_rise) nrise++;
    end
  endtask

  task automatic test_idle_stall();
    int stall_k;
    stall_k = -1;
    do_reset();
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk50);
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_bad++; $display("FAIL idle_cycle%0d: got %h expected %h", k, obs_all, exp_all);
      end
      if (stall && (stall_k < 0)) stall_k = k;
    end
    n_cmp++;
    if (stall_k !== 5000) begin
      n_bad++; $display("FAIL idle_stall_cycle: got %0d expected %0d", stall_k, 5000);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 0;
    do_reset();
    repeat (5) @(negedge clk50);
    force dut.frame_cnt_q = 16'hFFFF;
    cnt_offset = 16'hFFFF - m_rises;
    @(posedge clk50);
    #1;
    release dut.frame_cnt_q;
    vs_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk50);
      if (seen) begin
        n_cmp++;
        if ((frame_cnt !== 16'h0000) || (obs_all !== exp_all)) begin
          n_bad++; $display("FAIL frame_cnt_wrap: got %h expected %h", frame_cnt, 16'h0000);
        end
        break;
      end
      if (vs_rise) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL wrap_rise_timeout: got no rise expected rise within 20 cycles");
    end
  endtask

  task automatic test_midreset();
    int nrise;
    bit prev_rise;
    nrise = 0; prev_rise = 0;
    do_reset();
    repeat (10) @(negedge clk50);
    for (int k = 0; k < 2300; k++) begin
      vs_raw = ((k % 1000) < 500);
      @(negedge clk50);
    end
    n_cmp++;
    if ((period_valid !== 1'b1) || (frame_cnt !== 16'd3)) begin
      n_bad++; $display("FAIL midreset_prelock: got valid=%0b cnt=%0d expected valid=1 cnt=3",
                        period_valid, frame_cnt);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_all !== 52'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h expected %h", obs_all, 52'd0);
    end
    vs_raw = 1'b0; cnt_offset = 0;
    repeat (2) @(negedge clk50);
    rst = 1'b0;
    for (int k = 0; k < 2100; k++) begin
      vs_raw = ((k % 1000) < 500);
      @(negedge clk50);
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_bad++; $display("FAIL midreset_cycle%0d: got %h expected %h", k, obs_all, exp_all);
      end
      if (prev_rise && (nrise == 1)) begin
        n_cmp++;
        if ((period_valid !== 1'b0) || (frame_cnt !== 16'd1)) begin
          n_bad++; $display("FAIL midreset_armed: got valid=%0b cnt=%0d expected valid=0 cnt=1",
                            period_valid, frame_cnt);
        end
      end
      prev_rise = vs_rise;
      if (vs_rise) nrise++;
    end
  endtask

  task automatic test_random();
    int hold;
    logic lvl;
    hold = 0; lvl = 1'b0;
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      if (hold == 0) begin
        lvl  = ~lvl;
        hold = (($urandom % 4) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 300));
      end
      vs_raw = lvl;
      hold--;
      @(negedge clk50);
      n_cmp++;
      if (obs_all !== exp_all) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h expected %h", k, obs_all, exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_square();
    test_stall();
    test_idle_stall();
    test_wrap();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
